// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - glyph table, segment type and parameter checks for seg_scan_mux
package seg_scan_pkg;

    typedef logic [6:0] seg_t;

    // Bit order {a,b,c,d,e,f,g}, 1 = lit
    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t GLYPHS [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic bit params_ok(int digits, int scan_div);
        return (digits >= 2) && (digits <= 16) && (scan_div >= 2);
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational hex nibble to seven-segment glyph with blanking
module seg_hex_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : GLYPHS[nibble];
    end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - N-digit seven-segment scanner with frame-aligned double buffering
// Optional SEG_SCAN_LZS_EN adds leading-zero suppression.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int P_DIGITS   = 4,
    parameter int P_SCAN_DIV = 1000000
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [4*P_DIGITS-1:0] I_value,
    input  logic [P_DIGITS-1:0]   I_blank_mask,
    input  logic                  I_load,
    output logic                  O_ack,
    output logic [6:0]            O_seg,
    output logic [P_DIGITS-1:0]   O_an
);

    localparam int CNT_W = $clog2(P_SCAN_DIV);
    localparam int IDX_W = $clog2(P_DIGITS);

    generate
        if (!params_ok(P_DIGITS, P_SCAN_DIV)) begin : g_bad_params
            $error("seg_scan_mux: illegal P_DIGITS or P_SCAN_DIV");
        end
    endgenerate

    typedef enum logic {START, SCAN} state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [IDX_W-1:0]      idx, idx_next;
    logic                  pending;
    logic [4*P_DIGITS-1:0] shadow_value, disp_value, disp_value_next;
    logic [P_DIGITS-1:0]   shadow_blank, disp_blank, disp_blank_next;
    logic [P_DIGITS-1:0]   lz_mask, an_next;
    logic                  tick, commit, all_zero, mux_blank;
    logic [3:0]            mux_nibble;
    seg_t                  dec_seg;
    logic [6:0]            seg_next;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        commit     = 1'b0;
        tick       = (cnt == CNT_W'(P_SCAN_DIV - 1));
        cnt_next   = tick ? '0 : cnt + CNT_W'(1);
        case (state)
            START: if (tick) begin
                state_next = SCAN;
                idx_next   = '0;
                commit     = pending;
            end
            SCAN: if (tick) begin
                if (idx == IDX_W'(P_DIGITS - 1)) begin
                    idx_next = '0;
                    commit   = pending;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            default: state_next = START;
        endcase
        disp_value_next = commit ? shadow_value : disp_value;
        disp_blank_next = commit ? shadow_blank : disp_blank;
    end

    // Outputs are registered from the post-edge view so a commit is visible with its ack
    always_comb begin
        lz_mask  = '0;
        all_zero = 1'b1;
`ifdef SEG_SCAN_LZS_EN
        for (int k = P_DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero && (disp_value_next[4*k +: 4] == 4'h0);
            lz_mask[k] = all_zero;
        end
`endif
        mux_nibble = 4'h0;
        mux_blank  = 1'b0;
        for (int k = 0; k < P_DIGITS; k++) begin
            if (idx_next == IDX_W'(k)) begin
                mux_nibble = disp_value_next[4*k +: 4];
                mux_blank  = disp_blank_next[k] | lz_mask[k];
            end
        end
    end

    seg_hex_decoder u_dec (
        .nibble (mux_nibble),
        .blank  (mux_blank),
        .seg    (dec_seg)
    );

    always_comb begin
        an_next  = '0;
        seg_next = 7'b0;
        if (state_next == SCAN) begin
            an_next  = P_DIGITS'(1) << idx_next;
            seg_next = dec_seg;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            cnt          <= '0;
            idx          <= '0;
            pending      <= 1'b0;
            shadow_value <= '0;
            shadow_blank <= '0;
            disp_value   <= '0;
            disp_blank   <= '0;
            O_ack        <= 1'b0;
            O_seg        <= 7'b0;
            O_an         <= '0;
        end else begin
            cnt        <= cnt_next;
            idx        <= idx_next;
            disp_value <= disp_value_next;
            disp_blank <= disp_blank_next;
            O_ack      <= commit;
            O_seg      <= seg_next;
            O_an       <= an_next;
            // A load in the commit cycle wins: it re-arms pending for the next frame
            if (I_load) begin
                shadow_value <= I_value;
                shadow_blank <= I_blank_mask;
                pending      <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed self-checking bench for seg_scan_mux (4 digits, 4 clocks per slot)
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  mask = 4'h0;
    logic        load = 1'b0;
    logic        ack;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_count = 0;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] GF = 7'b1000111;

    seg_scan_mux #(.P_DIGITS(4), .P_SCAN_DIV(4)) dut (
        .I_clk        (clk),
        .I_rst        (rst_n),
        .I_value      (value),
        .I_blank_mask (mask),
        .I_load       (load),
        .O_ack        (ack),
        .O_seg        (seg),
        .O_an         (an)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ack === 1'b1) ack_count++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] m);
        value = v;
        mask  = m;
        load  = 1'b1;
        step();
        load  = 1'b0;
        mask  = 4'h0;
    endtask

    initial begin
        logic [6:0] lz_exp;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_an", an, 0);
        chk("reset_ack", ack, 0);
        rst_n = 1'b1;
        cyc = 0;
        ack_count = 0;

        for (int c = 0; c < 4; c++) begin
            chk("start_an", an, 0);
            chk("start_seg", seg, 0);
            step();
        end
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 4; s++) begin
                chk("scan_an", an, 32'(4'b0001 << d));
                chk("scan_seg", seg, G0);
                step();
            end
        end
        chk("wrap_an", an, 4'b0001);

        // Mid-frame load of 12AF, committed at cycle 36
        run_to(25);
        pulse_load(16'h12AF, 4'h0);
        run_to(32);
        chk("pre_commit_seg", seg, G0);
        chk("pre_commit_an", an, 4'b1000);
        run_to(35);
        chk("no_early_ack", ack_count, 0);
        step();
        chk("commit_ack", ack, 1);
        chk("commit_seg_d0", seg, GF);
        chk("commit_an_d0", an, 4'b0001);
        step();
        chk("ack_one_cycle", ack, 0);
        run_to(40);
        chk("commit_seg_d1", seg, GA);
        chk("commit_an_d1", an, 4'b0010);

        // Two loads in one frame: one ack, latest wins
        run_to(41);
        pulse_load(16'h1111, 4'h0);
        run_to(44);
        chk("commit_seg_d2", seg, G2);
        run_to(45);
        pulse_load(16'h2222, 4'h0);
        run_to(48);
        chk("commit_seg_d3", seg, G1);
        ack_count = 0;
        run_to(52);
        chk("b2b_ack", ack, 1);
        chk("b2b_seg_d0", seg, G2);
        for (int d = 1; d < 4; d++) begin
            run_to(52 + 4 * d);
            chk("b2b_seg", seg, G2);
            chk("b2b_an", an, 32'(4'b0001 << d));
        end
        run_to(67);
        chk("b2b_single_ack", ack_count, 1);

        // Load on the boundary tick (cycle 67) with nothing pending
        ack_count = 0;
        pulse_load(16'h4444, 4'h0);
        chk("edge_no_ack", ack, 0);
        chk("edge_old_seg", seg, G2);
        run_to(84);
        chk("edge_late_ack", ack, 1);
        chk("edge_new_seg", seg, G4);
        chk("edge_ack_count", ack_count, 1);

        // Blanking
        run_to(90);
        pulse_load(16'h8888, 4'b0101);
        run_to(100);
        chk("blank_ack", ack, 1);
        chk("blank_d0", seg, 0);
        run_to(104);
        chk("blank_d1", seg, G8);
        chk("blank_an_d1", an, 4'b0010);
        run_to(108);
        chk("blank_d2", seg, 0);
        run_to(112);
        chk("blank_d3", seg, G8);

        // Leading zeros
`ifdef SEG_SCAN_LZS_EN
        lz_exp = 7'b0;
`else
        lz_exp = G0;
`endif
        run_to(118);
        pulse_load(16'h0030, 4'h0);
        run_to(132);
        chk("lz_ack", ack, 1);
        chk("lz_d0", seg, G0);
        run_to(136);
        chk("lz_d1", seg, G3);
        run_to(140);
        chk("lz_d2", seg, lz_exp);
        run_to(144);
        chk("lz_d3", seg, lz_exp);

        // Asynchronous reset mid-slot with a load pending
        run_to(150);
        pulse_load(16'h5555, 4'h0);
        run_to(153);
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", an, 0);
        chk("async_rst_seg", seg, 0);
        chk("async_rst_ack", ack, 0);
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        ack_count = 0;
        chk("rerun_an", an, 0);
        run_to(4);
        chk("rerun_first_an", an, 4'b0001);
        chk("rerun_first_seg", seg, G0);
        run_to(20);
        chk("rerun_f1_seg", seg, G0);
        run_to(36);
        chk("rerun_f2_seg", seg, G0);
        run_to(40);
        chk("rerun_no_ack", ack_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
